// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file with write-back bypass, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [31:0]           i_instruction,
  input  logic [DATA_W-1:0]     i_pc4,
  input  logic                  i_we_wb,
  input  logic [REG_ADDR_W-1:0] i_wr_addr_wb,
  input  logic [DATA_W-1:0]     i_wr_data_wb,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_flush,
  input  logic                  i_stall_ext,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0]     o_reg_da,
  output logic [DATA_W-1:0]     o_reg_db,
  output logic [DATA_W-1:0]     o_imm_ext,
  output logic [5:0]            o_opcode,
  output logic [4:0]            o_shamt,
  output logic [5:0]            o_funct,
  output logic [25:0]           o_jaddr,
  output logic [DATA_W-1:0]     o_pc4
);

  localparam int unsigned NREGS = 2**REG_ADDR_W;

  logic [DATA_W-1:0]     regs [NREGS];
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [5:0]            opcode;
  logic [15:0]           imm16;
  logic [DATA_W-1:0]     rd_a, rd_b, imm_ext;

  assign rs     = REG_ADDR_W'(i_instruction[25:21]);
  assign rt     = REG_ADDR_W'(i_instruction[20:16]);
  assign rd     = REG_ADDR_W'(i_instruction[15:11]);
  assign opcode = i_instruction[31:26];
  assign imm16  = i_instruction[15:0];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_we_wb && i_wr_addr_wb != '0) begin
      regs[i_wr_addr_wb] <= i_wr_data_wb;
    end
  end

  // Write-back data is bypassed so a same-cycle read sees the value being written.
  assign rd_a = (rs == '0) ? '0 :
                (i_we_wb && i_wr_addr_wb == rs) ? i_wr_data_wb : regs[rs];
  assign rd_b = (rt == '0) ? '0 :
                (i_we_wb && i_wr_addr_wb == rt) ? i_wr_data_wb : regs[rt];

  always_comb begin
    imm_ext = DATA_W'(signed'(imm16));
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_W'(imm16);
      6'h0F:               imm_ext = DATA_W'(signed'({imm16, 16'h0000}));
      default:             imm_ext = DATA_W'(signed'(imm16));
    endcase
  end

  assign o_stall = i_valid & i_ex_mem_read & (i_ex_rt != '0) &
                   ((i_ex_rt == rs) | (i_ex_rt == rt));

  // Flush and load-use bubble share one path: data fields load (don't-care),
  // control fields clear. stall_ext holds only when no flush is pending.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
      o_opcode  <= '0;
      o_funct   <= '0;
      o_reg_da  <= '0;
      o_reg_db  <= '0;
      o_imm_ext <= '0;
      o_shamt   <= '0;
      o_jaddr   <= '0;
      o_pc4     <= '0;
    end else if (!(i_stall_ext && !i_flush)) begin
      o_reg_da  <= rd_a;
      o_reg_db  <= rd_b;
      o_imm_ext <= imm_ext;
      o_shamt   <= i_instruction[10:6];
      o_jaddr   <= i_instruction[25:0];
      o_pc4     <= i_pc4;
      if (i_flush || o_stall) begin
        o_valid  <= 1'b0;
        o_rs     <= '0;
        o_rt     <= '0;
        o_rd     <= '0;
        o_opcode <= '0;
        o_funct  <= '0;
      end else begin
        o_valid  <= i_valid;
        o_rs     <= rs;
        o_rt     <= rt;
        o_rd     <= rd;
        o_opcode <= opcode;
        o_funct  <= i_instruction[5:0];
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a reference model predicts each ID/EX load,
// queues it at drive time and compares it one clock later.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic [31:0] i_pc4;
  logic        i_we_wb;
  logic [4:0]  i_wr_addr_wb;
  logic [31:0] i_wr_data_wb;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        i_flush;
  logic        i_stall_ext;
  logic        o_stall, o_valid;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [31:0] o_reg_da, o_reg_db, o_imm_ext, o_pc4;
  logic [5:0]  o_opcode, o_funct;
  logic [25:0] o_jaddr;

  id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc4(i_pc4), .i_we_wb(i_we_wb), .i_wr_addr_wb(i_wr_addr_wb),
    .i_wr_data_wb(i_wr_data_wb), .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .i_flush(i_flush), .i_stall_ext(i_stall_ext), .o_stall(o_stall), .o_valid(o_valid),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_reg_da(o_reg_da), .o_reg_db(o_reg_db),
    .o_imm_ext(o_imm_ext), .o_opcode(o_opcode), .o_shamt(o_shamt), .o_funct(o_funct),
    .o_jaddr(o_jaddr), .o_pc4(o_pc4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] da, db, imm, pc4;
    logic [4:0]  shamt;
    logic [25:0] jaddr;
    logic        data_ok;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] mregs [32];
  int          tests = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (i_we_wb && i_wr_addr_wb == idx) return i_wr_data_wb;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] m_imm(input logic [5:0] op, input logic [15:0] imm);
    case (op)
      6'h0C, 6'h0D, 6'h0E: return {16'h0000, imm};
      6'h0F:               return {imm, 16'h0000};
      default:             return {{16{imm[15]}}, imm};
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic idle();
    i_valid = 1'b1; i_we_wb = 1'b0; i_wr_addr_wb = '0; i_wr_data_wb = '0;
    i_ex_mem_read = 1'b0; i_ex_rt = '0; i_flush = 1'b0; i_stall_ext = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    cur = '0;
    cur.data_ok = 1'b1;
  endtask

  // Inputs are already driven; predict, queue, clock, then pop and compare.
  task automatic step(input string tag);
    exp_t       e;
    logic [4:0] mrs, mrt;
    logic       stall_e;
    #1;
    mrs = i_instruction[25:21];
    mrt = i_instruction[20:16];
    stall_e = i_valid && i_ex_mem_read && i_ex_rt != 5'd0 && (i_ex_rt == mrs || i_ex_rt == mrt);
    check({tag, ".stall"}, {63'b0, o_stall}, {63'b0, stall_e});
    if (i_flush || (!i_stall_ext && stall_e)) begin
      cur = '0;
    end else if (!i_stall_ext) begin
      cur.v = i_valid; cur.op = i_instruction[31:26]; cur.fn = i_instruction[5:0];
      cur.rs = mrs; cur.rt = mrt; cur.rd = i_instruction[15:11];
      cur.da = m_read(mrs); cur.db = m_read(mrt);
      cur.imm = m_imm(i_instruction[31:26], i_instruction[15:0]);
      cur.pc4 = i_pc4; cur.shamt = i_instruction[10:6]; cur.jaddr = i_instruction[25:0];
      cur.data_ok = 1'b1;
    end
    sb.push_back(cur);
    @(posedge clk);
    if (i_we_wb && i_wr_addr_wb != 5'd0) mregs[i_wr_addr_wb] = i_wr_data_wb;
    #1;
    e = sb.pop_front();
    check({tag, ".valid"}, {63'b0, o_valid}, {63'b0, e.v});
    check({tag, ".opcode"}, {58'b0, o_opcode}, {58'b0, e.op});
    check({tag, ".funct"}, {58'b0, o_funct}, {58'b0, e.fn});
    check({tag, ".rs"}, {59'b0, o_rs}, {59'b0, e.rs});
    check({tag, ".rt"}, {59'b0, o_rt}, {59'b0, e.rt});
    check({tag, ".rd"}, {59'b0, o_rd}, {59'b0, e.rd});
    if (e.data_ok) begin
      check({tag, ".da"}, {32'b0, o_reg_da}, {32'b0, e.da});
      check({tag, ".db"}, {32'b0, o_reg_db}, {32'b0, e.db});
      check({tag, ".imm"}, {32'b0, o_imm_ext}, {32'b0, e.imm});
      check({tag, ".pc4"}, {32'b0, o_pc4}, {32'b0, e.pc4});
      check({tag, ".shamt"}, {59'b0, o_shamt}, {59'b0, e.shamt});
      check({tag, ".jaddr"}, {38'b0, o_jaddr}, {38'b0, e.jaddr});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, {63'b0, o_valid}, 64'h0);
    check({tag, ".opcode"}, {58'b0, o_opcode}, 64'h0);
    check({tag, ".rs"}, {59'b0, o_rs}, 64'h0);
    check({tag, ".da"}, {32'b0, o_reg_da}, 64'h0);
    check({tag, ".imm"}, {32'b0, o_imm_ext}, 64'h0);
    check({tag, ".pc4"}, {32'b0, o_pc4}, 64'h0);
    check({tag, ".jaddr"}, {38'b0, o_jaddr}, 64'h0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle();
    i_instruction = '0;
    i_pc4 = '0;
    model_reset();
    #12;
    check_reset_outputs("por");
    i_rst_n = 1'b1;

    // Preload r5 and get real contents into ID/EX, then reset mid-operation.
    i_we_wb = 1'b1; i_wr_addr_wb = 5'd5; i_wr_data_wb = 32'h0000_0055;
    i_instruction = mk_i(6'h08, 5'd5, 5'd6, 16'h1234); i_pc4 = 32'h104;
    step("preload");
    idle();
    i_instruction = mk_r(6'h00, 5'd5, 5'd5, 5'd7, 5'd3, 6'h20); i_pc4 = 32'h108;
    step("read_r5");
    i_rst_n = 1'b0;
    #3;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #2;
    i_rst_n = 1'b1;
    i_instruction = mk_r(6'h00, 5'd5, 5'd0, 5'd7, 5'd0, 6'h20); i_pc4 = 32'h200;
    step("r5_cleared");

    // r0 stays zero even when written, including the same-cycle bypass path.
    i_we_wb = 1'b1; i_wr_addr_wb = 5'd0; i_wr_data_wb = 32'h0000_DEAD;
    i_instruction = mk_r(6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20); i_pc4 = 32'h204;
    step("r0_wr");
    idle();
    step("r0_rd");

    // Same-cycle write-back bypass on both ports, then regfile read-back.
    i_we_wb = 1'b1; i_wr_addr_wb = 5'd8; i_wr_data_wb = 32'h0000_1234;
    i_instruction = mk_r(6'h00, 5'd8, 5'd8, 5'd9, 5'd0, 6'h20); i_pc4 = 32'h208;
    step("bypass");
    idle();
    i_instruction = mk_r(6'h00, 5'd3, 5'd8, 5'd9, 5'd0, 6'h22); i_pc4 = 32'h20C;
    step("r8_rb");

    // Load-use hazard produces a bubble; clears the next cycle.
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd9;
    i_instruction = mk_r(6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20); i_pc4 = 32'h210;
    step("hazard");
    i_ex_mem_read = 1'b0;
    step("after_haz");
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd8;
    i_instruction = mk_r(6'h00, 5'd8, 5'd2, 5'd10, 5'd0, 6'h20);
    step("haz_rs");
    i_ex_rt = 5'd0; i_instruction = mk_r(6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
    step("haz_r0");
    i_ex_rt = 5'd8; i_valid = 1'b0; i_instruction = mk_r(6'h00, 5'd8, 5'd8, 5'd1, 5'd0, 6'h20);
    step("haz_inval");
    idle();

    // Immediate extension flavours.
    i_instruction = mk_i(6'h08, 5'd1, 5'd2, 16'h8001); step("imm_08");
    i_instruction = mk_i(6'h0D, 5'd1, 5'd2, 16'h8001); step("imm_0d");
    i_instruction = mk_i(6'h0F, 5'd0, 5'd2, 16'h8001); step("imm_0f");
    i_instruction = mk_i(6'h0C, 5'd1, 5'd2, 16'hF00F); step("imm_0c");
    i_instruction = mk_i(6'h23, 5'd1, 5'd2, 16'h7FFF); step("imm_23");

    // Flush wins over stall_ext; stall_ext alone holds while WB still writes.
    i_instruction = mk_r(6'h00, 5'd8, 5'd8, 5'd4, 5'd1, 6'h20); i_pc4 = 32'h300;
    step("pre_flush");
    i_flush = 1'b1; i_stall_ext = 1'b1;
    step("flush_stall");
    idle();
    i_instruction = mk_i(6'h08, 5'd8, 5'd11, 16'h0042); i_pc4 = 32'h304;
    step("pre_hold");
    for (int k = 0; k < 3; k++) begin
      i_stall_ext = 1'b1; i_we_wb = 1'b1; i_wr_addr_wb = 5'd11 + 5'(k);
      i_wr_data_wb = 32'hA000_0000 + 32'(k);
      i_instruction = mk_r(6'h00, 5'd11, 5'd12, 5'd13, 5'd2, 6'h25); i_pc4 = 32'h400 + 32'(k);
      step("hold");
    end
    idle();
    i_instruction = mk_r(6'h00, 5'd12, 5'd13, 5'd1, 5'd0, 6'h20); i_pc4 = 32'h310;
    step("post_hold");

    // Random mix of all controls.
    for (int n = 0; n < 80; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_instruction = $urandom;
      i_pc4 = $urandom;
      i_we_wb = $urandom_range(0, 1) != 0;
      i_wr_addr_wb = ($urandom_range(0, 2) == 0) ? i_instruction[25:21] : 5'($urandom_range(0, 31));
      i_wr_data_wb = $urandom;
      i_ex_mem_read = ($urandom_range(0, 2) == 0);
      i_ex_rt = ($urandom_range(0, 1) != 0) ? i_instruction[20:16] : 5'($urandom_range(0, 31));
      i_flush = ($urandom_range(0, 9) == 0);
      i_stall_ext = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
